// File: rtl/jtframe_vtgen_pkg.sv
// Shared video definitions for the jtframe video timing generator.
// Holds the test pattern codes used by the timing core and colour sub-module.
package jtframe_vtgen_pkg;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    BARS  = 2'd1,
    GRID  = 2'd2,
    GRAD  = 2'd3
  } pat_e;

  // Widest colour channel the gradient slice H[7:8-WCOL] can feed.
  localparam int MAX_WCOL = 8;

  // Narrowest counter able to supply the H[7:0]/V[7:0] pattern bits.
  localparam int MIN_CW = 8;

endpackage

// File: rtl/jtframe_vtgen_pattern.sv
// Combinational test pattern colour generator.
// Ports: h/v (low 8 bits of position), pat, frame, blank -> r/g/b colour.
module jtframe_vtgen_pattern
  import jtframe_vtgen_pkg::*;
#(
  parameter int WCOL = 4
) (
  input  logic [7:0]      h,
  input  logic [7:0]      v,
  input  logic [1:0]      pat,
  input  logic            frame,
  input  logic            blank,
  output logic [WCOL-1:0] r,
  output logic [WCOL-1:0] g,
  output logic [WCOL-1:0] b
);

  logic [2:0] idx;
  logic       line;

  always_comb begin
    r    = '0;
    g    = '0;
    b    = '0;
    idx  = h[7:5];
    line = (h[3:0] == 4'd0) || (v[3:0] == 4'd0);
    if (!blank) begin
      unique case (1'b1)
        pat == BARS: begin
          r = {WCOL{idx[2]}};
          g = {WCOL{idx[1]}};
          b = {WCOL{idx[0]}};
        end
        pat == GRID: begin
          r = {WCOL{line}};
          g = {WCOL{line}};
          b = {WCOL{line}};
        end
        pat == GRAD: begin
          r = h[7:8-WCOL];
          g = v[7:8-WCOL];
          b = {WCOL{frame}};
        end
        default: begin
          r = '0;
          g = '0;
          b = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/jtframe_vtgen.sv
// Video timing generator: H/V counters, sync/blank, frame toggle, test colour.
// Ports: clk, rst, pxl_cen, pattern in; H, V, HS, VS, HB, VB, rgb, frame out.
module jtframe_vtgen
  import jtframe_vtgen_pkg::*;
#(
  parameter int WCOL     = 4,
  parameter int HTOTAL   = 384,
  parameter int HB_START = 256,
  parameter int HS_START = 288,
  parameter int HS_END   = 320,
  parameter int VTOTAL   = 264,
  parameter int VB_START = 224,
  parameter int VS_START = 234,
  parameter int VS_END   = 237,
  parameter int HW       = 9,
  parameter int VW       = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pxl_cen,
  input  logic [1:0]      pattern,
  output logic [HW-1:0]   H,
  output logic [VW-1:0]   V,
  output logic            HS,
  output logic            VS,
  output logic            HB,
  output logic            VB,
  output logic [WCOL-1:0] r_out,
  output logic [WCOL-1:0] g_out,
  output logic [WCOL-1:0] b_out,
  output logic            frame
);

  localparam bit LEGAL =
    (HB_START < HS_START) && (HS_START < HS_END) &&
    (HS_END <= HTOTAL) &&
    (VB_START <= VS_START) && (VS_START < VS_END) &&
    (VS_END < VTOTAL) &&
    (HTOTAL <= 2**HW) && (VTOTAL <= 2**VW) &&
    (HW >= MIN_CW) && (VW >= MIN_CW) &&
    (WCOL >= 1) && (WCOL <= MAX_WCOL);

  generate
    if (!LEGAL) begin : g_bad_params
      $error("jtframe_vtgen: illegal timing parameters");
    end
  endgenerate

  localparam logic [HW-1:0] HLAST = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] VLAST = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] HB_S  = HW'(HB_START);
  localparam logic [HW-1:0] HS_S  = HW'(HS_START);
  localparam logic [HW-1:0] HS_E  = HW'(HS_END);
  localparam logic [VW-1:0] VB_S  = VW'(VB_START);
  localparam logic [VW-1:0] VS_S  = VW'(VS_START);
  localparam logic [VW-1:0] VS_E  = VW'(VS_END);

  logic [HW-1:0]   nh;
  logic [VW-1:0]   nv;
  logic            hwrap;
  logic            fwrap;
  logic            hb_n;
  logic            hs_n;
  logic            vb_n;
  logic            vs_n;
  logic            frame_n;
  logic [1:0]      pat_q;
  logic [1:0]      pat_n;
  logic [WCOL-1:0] r_n;
  logic [WCOL-1:0] g_n;
  logic [WCOL-1:0] b_n;

  // Every output is derived from the next counter values, so the
  // registered sync, blank and colour line up with H/V on the same edge.
  always_comb begin
    hwrap = (H == HLAST);
    fwrap = hwrap && (V == VLAST);
    nh    = hwrap ? '0 : H + 1'b1;
    nv    = V;
    if (hwrap) nv = (V == VLAST) ? '0 : V + 1'b1;
    hb_n  = (nh >= HB_S);
    hs_n  = (nh >= HS_S) && (nh < HS_E);
    vb_n  = (nv >= VB_S);
    vs_n  = VS;
    if (nh == HS_S && nv == VS_S) vs_n = 1'b1;
    if (nh == HS_S && nv == VS_E) vs_n = 1'b0;
    frame_n = frame ^ fwrap;
    pat_n   = fwrap ? pattern : pat_q;
  end

  jtframe_vtgen_pattern #(
    .WCOL (WCOL)
  ) u_pattern (
    .h     (nh[7:0]),
    .v     (nv[7:0]),
    .pat   (pat_n),
    .frame (frame_n),
    .blank (hb_n | vb_n),
    .r     (r_n),
    .g     (g_n),
    .b     (b_n)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      H     <= '0;
      V     <= '0;
      HS    <= 1'b0;
      VS    <= 1'b0;
      HB    <= 1'b0;
      VB    <= 1'b0;
      r_out <= '0;
      g_out <= '0;
      b_out <= '0;
      frame <= 1'b0;
      pat_q <= BLACK;
    end else if (pxl_cen) begin
      H     <= nh;
      V     <= nv;
      HS    <= hs_n;
      VS    <= vs_n;
      HB    <= hb_n;
      VB    <= vb_n;
      r_out <= r_n;
      g_out <= g_n;
      b_out <= b_n;
      frame <= frame_n;
      pat_q <= pat_n;
    end
  end

endmodule

// File: tb/tb_jtframe_vtgen.sv
// Directed bench for jtframe_vtgen with a shortened vertical total.
// Horizontal timing uses the defaults; vertical events scaled to 40 lines.
module tb_jtframe_vtgen;

  localparam int HT = 384;
  localparam int VT = 40;
  localparam int FT = HT * VT;

  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen;
  logic [1:0] pattern;
  logic [8:0] H;
  logic [8:0] V;
  logic       HS, VS, HB, VB;
  logic [3:0] r, g, b;
  logic       frame;
  logic [11:0] rgb;

  int n_cmp = 0;
  int n_bad = 0;
  int pos   = 0;

  assign rgb = {r, g, b};

  always #5 clk = ~clk;

  jtframe_vtgen #(
    .VTOTAL   (VT),
    .VB_START (32),
    .VS_START (34),
    .VS_END   (37)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .pxl_cen (pxl_cen),
    .pattern (pattern),
    .H       (H),
    .V       (V),
    .HS      (HS),
    .VS      (VS),
    .HB      (HB),
    .VB      (VB),
    .r_out   (r),
    .g_out   (g),
    .b_out   (b),
    .frame   (frame)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // n pixel enables on n consecutive clk edges
  task automatic run(input int n);
    if (n > 0) begin
      @(negedge clk) pxl_cen = 1'b1;
      repeat (n) @(negedge clk);
      pxl_cen = 1'b0;
      pos = (pos + n) % FT;
    end
  endtask

  task automatic goto(input int h, input int v);
    run(((v * HT + h) - pos + FT) % FT);
  endtask

  task automatic chk_hv(input string tag,
                        input int h, input int v);
    chk({tag, "_H"}, 32'(H), h);
    chk({tag, "_V"}, 32'(V), v);
  endtask

  initial begin
    rst     = 1'b1;
    pxl_cen = 1'b0;
    pattern = 2'd0;
    repeat (3) @(negedge clk);
    chk_hv("rst", 0, 0);
    chk("rst_sync", {HS, VS, HB, VB}, 0);
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_frame", 32'(frame), 0);

    @(negedge clk) rst = 1'b0;
    pos = 0;
    run(1);
    chk_hv("first", 1, 0);

    for (int i = 2; i <= HT; i++) begin
      run(1);
      chk("l0_H", 32'(H), i % HT);
      chk("l0_HB", 32'(HB), 32'((i % HT) >= 256));
      chk("l0_HS", 32'(HS),
          32'((i % HT) >= 288 && (i % HT) < 320));
    end
    chk_hv("l0_wrap", 0, 1);

    goto(0, 20);
    pattern = 2'd1;
    goto(64, 20);
    chk("midframe_pat", 32'(rgb), 0);

    goto(0, 31);
    chk("vb_31", 32'(VB), 0);
    goto(0, 32);
    chk("vb_32", 32'(VB), 1);

    goto(0, 34);
    chk("vs_34_0", 32'(VS), 0);
    for (int i = 1; i < HT; i++) begin
      run(1);
      chk("vs_rise", 32'(VS), 32'(i >= 288));
    end
    chk("vs_35_0", 32'(VS), 1);
    goto(0, 37);
    chk("vs_37_0", 32'(VS), 1);
    for (int i = 1; i < HT; i++) begin
      run(1);
      chk("vs_fall", 32'(VS), 32'(i < 288));
    end

    goto(HT - 1, VT - 1);
    chk("pre_wrap_rgb", 32'(rgb), 0);
    chk("pre_wrap_frame", 32'(frame), 0);
    run(1);
    chk_hv("fwrap", 0, 0);
    chk("frame1", 32'(frame), 1);
    goto(64, 0);
    chk("bars_64", 32'(rgb), 32'h0F0);
    goto(160, 0);
    chk("bars_160", 32'(rgb), 32'hF0F);
    goto(224, 0);
    chk("bars_224", 32'(rgb), 32'hFFF);

    goto(0, 5);
    pattern = 2'd2;
    goto(32, 5);
    chk("bars_hold", 32'(rgb), 32'h00F);
    goto(0, 0);
    chk("frame2", 32'(frame), 0);
    goto(5, 16);
    chk("grid_5_16", 32'(rgb), 32'hFFF);
    goto(260, 16);
    chk("grid_blank", 32'(rgb), 0);
    goto(5, 17);
    chk("grid_5_17", 32'(rgb), 0);
    goto(16, 17);
    chk("grid_16_17", 32'(rgb), 32'hFFF);

    pattern = 2'd3;
    goto(0, 30);
    chk("grid_hold", 32'(rgb), 32'hFFF);
    goto(0, 0);
    chk("frame3", 32'(frame), 1);
    goto(160, 21);
    chk("grad", 32'(rgb), 32'hA1F);

    @(negedge clk);
    repeat (50) @(negedge clk);
    chk_hv("frz", 160, 21);
    chk("frz_rgb", 32'(rgb), 32'hA1F);
    chk("frz_sync", {HS, VS, HB, VB}, 0);
    chk("frz_frame", 32'(frame), 1);
    run(1);
    chk_hv("resume", 161, 21);

    goto(150, 22);
    chk("pre_rst_rgb", 32'(rgb), 32'h91F);
    #1 rst = 1'b1;
    #1;
    chk_hv("arst", 0, 0);
    chk("arst_rgb", 32'(rgb), 0);
    chk("arst_sync", {HS, VS, HB, VB}, 0);
    chk("arst_frame", 32'(frame), 0);
    @(negedge clk) rst = 1'b0;
    pos = 0;
    run(1);
    chk_hv("post_rst", 1, 0);
    goto(64, 0);
    chk("post_rst_black", 32'(rgb), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
